// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares one single-port data memory between the CPU MEM stage
// and a debug/loader port. The CPU wins by default; a debug request that has
// been refused MAX_WAIT times preempts the CPU for one cycle and is
// acknowledged on the following cycle.
// Optional build macro: DMEM_ARB_STATS_EN adds the stall_cnt/dbg_cnt counters.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [31:0]   dbg_rdata,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          owner
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   dbg_cnt
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic {
    ARB = 1'b0,  // normal arbitration
    ACK = 1'b1   // debug completion cycle; debug not eligible
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        wait_done;
  logic        dbg_grant;

  // With MAX_WAIT=0 a pending debug request is always past its patience.
  if (MAX_WAIT == 0) begin : g_no_wait
    assign wait_done = 1'b1;
  end else begin : g_wait
    assign wait_done = (wait_cnt >= MAX_WAIT_C);
  end

  // Grant is gated by reset so the memory strobes stay quiet while in reset.
  assign dbg_grant = reset && (state == ARB) && dbg_req && (!cpu_req || wait_done);

  assign owner     = dbg_grant;
  assign cpu_stall = cpu_req & dbg_grant;
  assign cpu_rdata = mem_rdata;
  assign dbg_ack   = (state == ACK);

  // Memory port steering: the granted requester drives address, data and strobes.
  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dbg_grant) begin
      mem_rd    = ~dbg_we;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (reset) begin
      mem_rd    = cpu_req & ~cpu_we;
      mem_we    = cpu_req & cpu_we;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      ARB: begin
        if (dbg_grant) begin
          state_nxt = ACK;
          wait_nxt  = '0;
        end else if (!dbg_req) begin
          wait_nxt  = '0;
        end else if (!wait_done) begin
          wait_nxt  = wait_cnt + 8'd1;
        end
      end
      ACK: begin
        state_nxt = ARB;
      end
      default: begin
        state_nxt = ARB;
        wait_nxt  = '0;
      end
    endcase
  end

  // State, wait counter and captured debug read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      wait_cnt  <= '0;
      dbg_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (dbg_grant) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating activity counters: CPU stall cycles and debug grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      dbg_cnt   <= '0;
    end else begin
      if (cpu_stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (dbg_grant && (dbg_cnt != 16'hFFFF)) begin
        dbg_cnt <= dbg_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Testbench for dmem_arbiter: randomized and directed stimulus, a reference
// model of the arbitration rules, and a scoreboard monitor sampling on the
// falling edge. A second instance with MAX_WAIT=0 covers immediate preemption.
module tb_dmem_arbiter;

  localparam int MW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [31:0]   cpu_wdata, dbg_wdata;
  logic [31:0]   cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, dbg_ack, mem_rd, mem_we, owner;
  logic [AW-1:0] mem_addr;

  logic [31:0]   cpu_rdata_0, dbg_rdata_0, mem_wdata_0, mem_rdata_0;
  logic          cpu_stall_0, dbg_ack_0, mem_rd_0, mem_we_0, owner_0;
  logic [AW-1:0] mem_addr_0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stall_cnt, dbg_cnt, stall_cnt_0, dbg_cnt_0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW), .AW(AW)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
`ifdef DMEM_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .dbg_cnt(dbg_cnt)
`endif
  );

  dmem_arbiter #(.MAX_WAIT(0), .AW(AW)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_0), .cpu_stall(cpu_stall_0),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack_0), .dbg_rdata(dbg_rdata_0),
    .mem_rd(mem_rd_0), .mem_we(mem_we_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0),
    .mem_rdata(mem_rdata_0), .owner(owner_0)
`ifdef DMEM_ARB_STATS_EN
    , .stall_cnt(stall_cnt_0), .dbg_cnt(dbg_cnt_0)
`endif
  );

  // Environment memory seen by the main DUT (16 words, indexed by low address bits).
  logic [31:0] dut_mem [16];
  assign mem_rdata   = dut_mem[mem_addr[3:0]];
  assign mem_rdata_0 = {16'hBEEF, mem_addr_0[15:0]};
  always @(posedge clk) if (mem_we) dut_mem[mem_addr[3:0]] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_mem [16];
  int m_wait, cyc, m_stalls, m_dbgs;
  bit m_in_ack;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic        owner, mem_rd, mem_we, stall, chk_rdata;
    logic [31:0] addr, wdata, rdata;
  } cyc_exp_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ack_exp_t;

  cyc_exp_t cyc_q[$];
  ack_exp_t ack_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs and push the model's expectations for it.
  task automatic drive_cycle(input bit c_req, input bit c_we, input logic [31:0] c_addr,
                             input logic [31:0] c_wdata, input bit d_req, input bit d_we,
                             input logic [31:0] d_addr, input logic [31:0] d_wdata);
    cyc_exp_t e;
    ack_exp_t a;
    bit grant;
    @(posedge clk); #1;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
    cyc++;
    grant = !m_in_ack && d_req && (!c_req || m_wait >= MW);
    e.cyc = cyc;
    e.owner = grant;
    e.stall = c_req && grant;
    e.rdata = '0;
    if (grant) begin
      e.mem_rd = !d_we; e.mem_we = d_we; e.addr = d_addr; e.wdata = d_wdata;
      e.chk_rdata = 1'b0;
      a.cyc = cyc + 1;
      a.data = ref_mem[d_addr[3:0]];
      ack_q.push_back(a);
      if (d_we) ref_mem[d_addr[3:0]] = d_wdata;
      m_wait = 0;
      m_dbgs++;
    end else begin
      e.mem_rd = c_req && !c_we; e.mem_we = c_req && c_we; e.addr = c_addr; e.wdata = c_wdata;
      e.chk_rdata = c_req && !c_we;
      e.rdata = ref_mem[c_addr[3:0]];
      if (c_req && c_we) ref_mem[c_addr[3:0]] = c_wdata;
      if (!d_req) m_wait = 0;
      else if (!m_in_ack && m_wait < MW) m_wait++;
    end
    if (e.stall) m_stalls++;
    m_in_ack = grant;
    cyc_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic drive_idle();
    drive_cycle(0, 0, $urandom(), $urandom(), 0, 0, $urandom(), $urandom());
  endtask

  // Both requesters held high for 10 cycles (debug wins on the 9th).
  task automatic run_starve();
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  1, 1'($urandom_range(0, 1)), $urandom(), $urandom());
    end
  endtask

  // Scoreboard monitor: compares the DUT against the queued expectations.
  initial begin : monitor
    cyc_exp_t e;
    ack_exp_t a;
    bit exp_ack;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cyc_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: got no expectation, required one (t=%0t)", $time);
        end else begin
          e = cyc_q.pop_front();
          check($sformatf("owner c%0d", e.cyc), owner, e.owner);
          check($sformatf("cpu_stall c%0d", e.cyc), cpu_stall, e.stall);
          check($sformatf("mem_rd c%0d", e.cyc), mem_rd, e.mem_rd);
          check($sformatf("mem_we c%0d", e.cyc), mem_we, e.mem_we);
          check($sformatf("mem_addr c%0d", e.cyc), mem_addr, e.addr);
          check($sformatf("mem_wdata c%0d", e.cyc), mem_wdata, e.wdata);
          if (e.chk_rdata) check($sformatf("cpu_rdata c%0d", e.cyc), cpu_rdata, e.rdata);
          exp_ack = (ack_q.size() > 0) && (ack_q[0].cyc == e.cyc);
          check($sformatf("dbg_ack c%0d", e.cyc), dbg_ack, exp_ack);
          if (exp_ack) begin
            a = ack_q.pop_front();
            check($sformatf("dbg_rdata c%0d", e.cyc), dbg_rdata, a.data);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit d_req;
    logic [31:0] d_addr, d_wdata;
    bit d_we;

    for (int i = 0; i < 16; i++) begin
      dut_mem[i] = $urandom();
      ref_mem[i] = dut_mem[i];
    end
    m_wait = 0; m_in_ack = 0; cyc = 0; m_stalls = 0; m_dbgs = 0;

    // Reset held with every requester active: strobes and acks must stay low.
    reset = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'h1234;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h8; dbg_wdata = 32'h5678;
    #3;
    check("rst mem_we", mem_we, 0);
    check("rst mem_rd", mem_rd, 0);
    check("rst cpu_stall", cpu_stall, 0);
    check("rst owner", owner, 0);
    check("rst dbg_ack", dbg_ack, 0);
    check("rst dbg_rdata", dbg_rdata, 0);
    @(negedge clk);
    cpu_req = 0; dbg_req = 0;
    reset = 1'b1;

    // CPU read with no debug traffic, then a lone debug write and its ACK cycle.
    drive_cycle(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    drive_cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'hA5);
    drive_cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'hA5);
    drive_idle();
    drive_cycle(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);

    // CPU starvation of the debug port until MAX_WAIT is reached.
    run_starve();
    drive_idle();

    // Randomized traffic with a level-held debug request.
    d_req = 0; d_we = 0; d_addr = $urandom(); d_wdata = $urandom();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        d_req = !d_req;
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom();
        d_wdata = $urandom();
      end
      drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  d_req, d_we, d_addr, d_wdata);
    end
    drive_idle();
    @(negedge clk); #1 mon_en = 1'b0;

    // Reset asserted in a debug grant cycle cancels the pending acknowledge.
    @(posedge clk); #1;
    cpu_req = 0; dbg_req = 0;
    @(posedge clk); #1;
    dbg_req = 1; dbg_we = 0; dbg_addr = $urandom();
    #1 check("pre_rst grant", owner, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst dbg_ack", dbg_ack, 0);
    check("mid_rst mem_rd", mem_rd, 0);
    check("mid_rst mem_we", mem_we, 0);
    check("mid_rst owner", owner, 0);
    check("mid_rst dbg_rdata", dbg_rdata, 0);
    dbg_req = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 check("post_rst dbg_ack", dbg_ack, 0);
    @(negedge clk) check("post_rst dbg_ack2", dbg_ack, 0);

    cyc_q.delete();
    ack_q.delete();
    m_wait = 0; m_in_ack = 0; m_stalls = 0; m_dbgs = 0;

    // Starvation scenario three times from a clean reset; the MAX_WAIT=0
    // instance must alternate debug and CPU ownership on the same stimulus.
    for (int r = 0; r < 3; r++) begin
      drive_idle();
      for (int k = 0; k < 10; k++) begin
        drive_cycle(1, 0, $urandom(), $urandom(), 1, 0, $urandom(), $urandom());
        #1;
        check($sformatf("mw0 owner r%0d k%0d", r, k), owner_0, (k % 2) == 0);
        check($sformatf("mw0 stall r%0d k%0d", r, k), cpu_stall_0, (k % 2) == 0);
        check($sformatf("mw0 ack r%0d k%0d", r, k), dbg_ack_0, (k % 2) == 1);
      end
    end
    drive_idle();
    @(negedge clk); #1 mon_en = 1'b0;

`ifdef DMEM_ARB_STATS_EN
    check("stall_cnt", stall_cnt, 3);
    check("dbg_cnt", dbg_cnt, 3);
    check("stall_cnt model", stall_cnt, m_stalls);
    check("dbg_cnt model", dbg_cnt, m_dbgs);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 8, is the number of cycles a pending debug request may be refused before it preempts the CPU (range 0..255).
REQ-002 Parameter: AW, default 32, is the address width.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: cpu_req  in  1  the CPU MEM stage needs memory this cycle (MemRead|MemWrite).
REQ-006 Port: cpu_we  in  1  CPU write (1) or read (0).
REQ-007 Port: cpu_addr  in  AW  CPU byte address.
REQ-008 Port: cpu_wdata  in  32  CPU store data.
REQ-009 Port: cpu_rdata  out  32  CPU load data, combinational from mem_rdata.
REQ-010 Port: cpu_stall  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers this cycle.
REQ-011 Port: dbg_req, dbg_we  in  1 each  debug/loader request level and write flag.
REQ-012 Port: dbg_addr  in  AW  debug address.
REQ-013 Port: dbg_wdata  in  32  debug write data.
REQ-014 Port: dbg_ack  out  1  one-cycle completion pulse.
REQ-015 Port: dbg_rdata  out  32  registered read data, valid while dbg_ack=1.
REQ-016 Port: mem_rd, mem_we  out  1 each  drive MemRead and MemWrite of the single-port data memory.
REQ-017 Port: mem_addr  out  AW  data memory address.
REQ-018 Port: mem_wdata  out  32  data memory write data.
REQ-019 Port: mem_rdata  in  32  data memory combinational read data.
REQ-020 Port: owner  out  1  0 = CPU, 1 = debug; combinational grant for this cycle.

Function
REQ-021 The FSM SHALL have two states, ARB (normal arbitration) and ACK (debug completion; debug is not eligible).
REQ-022 The per-cycle grant SHALL be decided combinationally:
- ARB, dbg_req=1 and (cpu_req=0 or wait_cnt>=MAX_WAIT) -> grant to debug.
- Otherwise -> grant to CPU.
- In ACK, the grant SHALL always go to the CPU.
REQ-023 The granted requester's we, addr and wdata SHALL drive the mem_* outputs.
REQ-024 With a CPU grant: mem_rd=cpu_req&~cpu_we and mem_we=cpu_req&cpu_we.
REQ-025 With a debug grant: mem_rd=~dbg_we and mem_we=dbg_we.
REQ-026 cpu_stall SHALL equal cpu_req & owner; the CPU access completes in the first non-stalled cycle.
REQ-027 On a debug grant the FSM SHALL go ARB->ACK, register dbg_rdata<=mem_rdata, and assert dbg_ack for exactly the next cycle.
REQ-028 The FSM SHALL go ACK->ARB unconditionally; a debug requester holding dbg_req high is re-eligible in the cycle after ACK.
REQ-029 wait_cnt (8 bit) SHALL behave as follows:
- Increments, saturating at MAX_WAIT, each ARB cycle where dbg_req=1 and the grant is to the CPU.
- Clears on a debug grant.
- Clears whenever dbg_req=0.
- Holds in ACK.
REQ-030 With MAX_WAIT=0, any eligible dbg_req SHALL win immediately.
REQ-031 With cpu_req=0 and no debug grant, mem_rd and mem_we SHALL both be 0.
REQ-032 Latency: a CPU access SHALL complete in 0 extra cycles when not preempted; a debug access SHALL be acknowledged 1 cycle after its grant.
REQ-033 Address bits SHALL pass through unmodified; alignment is the requester's responsibility.

Reset
REQ-034 While reset=0, the block SHALL asynchronously hold:
- state=ARB, wait_cnt=0, dbg_ack=0, dbg_rdata=0.
- mem_we=0, mem_rd=0, cpu_stall=0.
REQ-035 A reset asserted in the grant cycle SHALL cancel the pending dbg_ack; no ack SHALL follow reset release.

Configuration
REQ-036 Macro DMEM_ARB_STATS_EN: when defined, the block SHALL add two 16-bit outputs, stall_cnt and dbg_cnt.
- stall_cnt increments each cycle cpu_stall=1.
- dbg_cnt increments on each debug grant.
- Both saturate at 16'hFFFF and reset to 0.
REQ-037 When DMEM_ARB_STATS_EN is undefined, these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-038 cpu_req=1, cpu_we=0, addr=0x10, no dbg_req -> mem_rd=1, mem_addr=0x10, cpu_stall=0, cpu_rdata=mem_rdata in the same cycle.
REQ-039 cpu_req=0, dbg_req=1, dbg_we=1, addr=0x20, wdata=0xA5 -> mem_we=1 in that cycle; dbg_ack=1 next cycle; no re-grant in the ACK cycle.
REQ-040 cpu_req held 1, dbg_req held 1, MAX_WAIT=8 -> CPU owns 8 cycles; cycle 9 owner=1 and cpu_stall=1; cycle 10 owner=0 and dbg_ack=1.
REQ-041 MAX_WAIT=0, both requesting -> the debug grant is immediate; the CPU is stalled 1 cycle per debug access, alternating CPU/debug while dbg_req stays high.
REQ-042 reset driven 0 during a debug grant cycle -> dbg_ack stays 0; after release, wait_cnt=0 and state=ARB.
REQ-043 DMEM_ARB_STATS_EN defined, scenario REQ-040 repeated 3 times -> stall_cnt=3, dbg_cnt=3.
